// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: operands stream LSB-first through one
// full add/sub cell, with the inter-bit carry held in a flip-flop.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;

  logic             bit_a, bit_b, sum_bit, carry_nxt;
  logic [WIDTH-1:0] res_next;

  // Single add/sub cell: subtraction inverts b here and cin at preload.
  always_comb begin
    bit_a     = a_sh_q[0];
    bit_b     = b_sh_q[0] ^ sub_q;
    sum_bit   = bit_a ^ bit_b ^ carry_q;
    carry_nxt = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
    res_next  = {sum_bit, res_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    s_d      = s_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          sub_d   = sub;
          carry_d = cin ^ sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        carry_d  = carry_nxt;
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB during the final bit
          s_d     = res_next;
          cout_d  = carry_nxt ^ sub_q;
          ovf_d   = carry_q ^ carry_nxt;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand and partial-result shifters are always reloaded before use.
  always_ff @(posedge clk) begin
    a_sh_q   <= a_sh_d;
    b_sh_q   <= b_sh_d;
    res_sh_q <= res_sh_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
